// File: rtl/dispatch_packer_pkg.sv
// Shared definitions for the dispatch packer: uop field layout, default sizing
// and the branch-kill match used against buffered and incoming uops.
package dispatch_packer_pkg;

  localparam int unsigned OPC_W          = 7;
  localparam int unsigned LANES          = 4;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_WIDTH_REG  = 5;
  localparam int unsigned DEF_WIDTH_TAG  = 5;
  localparam int unsigned DEF_WIDTH_BRM  = 3;
  localparam int unsigned DEF_MAX_WAIT   = 3;

  function automatic int unsigned uop_width(input int unsigned w_brm, input int unsigned w_tag,
                                            input int unsigned w_reg);
    return OPC_W + w_brm + w_tag + 3 * w_reg + 3;
  endfunction

  // Layout from the top: opcode, branch mask, ROB tag, rs1, rs2, rd, 3 misc bits.
  function automatic int unsigned brm_lsb(input int unsigned width, input int unsigned w_brm);
    return width - OPC_W - w_brm;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned width, input int unsigned w_brm,
                                          input int unsigned w_tag);
    return brm_lsb(width, w_brm) - w_tag;
  endfunction

  localparam int unsigned DEF_WIDTH = uop_width(DEF_WIDTH_BRM, DEF_WIDTH_TAG, DEF_WIDTH_REG);
  localparam int unsigned OPC_MSB   = DEF_WIDTH - 1;
  localparam int unsigned BRM_LSB   = brm_lsb(DEF_WIDTH, DEF_WIDTH_BRM);
  localparam int unsigned TAG_LSB   = tag_lsb(DEF_WIDTH, DEF_WIDTH_BRM, DEF_WIDTH_TAG);
  localparam int unsigned RS1_LSB   = TAG_LSB - DEF_WIDTH_REG;
  localparam int unsigned RS2_LSB   = RS1_LSB - DEF_WIDTH_REG;
  localparam int unsigned RD_LSB    = RS2_LSB - DEF_WIDTH_REG;

  // Operands are zero-extended by the caller so any mask width shares one function.
  function automatic logic brm_hit(input logic [31:0] brm, input logic [31:0] kill);
    return |(brm & kill);
  endfunction

endpackage

// File: rtl/dispatch_packer_if.sv
// Rename-side and issue-side signals of the dispatch packer.
interface dispatch_packer_if
  import dispatch_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned WIDTH_BRM = DEF_WIDTH_BRM,
  parameter int unsigned DEPTH     = DEF_DEPTH
);
  logic [WIDTH-1:0]         i_inst;
  logic                     i_valid;
  logic                     o_ready;
  logic [WIDTH_BRM-1:0]     i_BrKill;
  logic                     i_stall;
  logic [WIDTH-1:0]         o_inst1;
  logic [WIDTH-1:0]         o_inst2;
  logic [WIDTH-1:0]         o_inst3;
  logic [WIDTH-1:0]         o_inst4;
  logic                     o_en;
  logic [$clog2(DEPTH):0]   o_count;

  modport master (
    output i_inst, i_valid, i_BrKill, i_stall,
    input  o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_en, o_count
  );

  modport slave (
    input  i_inst, i_valid, i_BrKill, i_stall,
    output o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_en, o_count
  );
endinterface

// File: rtl/dispatch_ring.sv
// Circular uop store with per-entry valid bits, branch-kill clearing and a
// four-entry read window starting at rd_ptr (killed/invalid entries read as zero).
module dispatch_ring
  import dispatch_packer_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned WIDTH_BRM = DEF_WIDTH_BRM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(DEPTH)-1:0]        wr_ptr,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic [WIDTH_BRM-1:0]            kill,
  input  logic [$clog2(DEPTH)-1:0]        rd_ptr,
  output logic [LANES-1:0][WIDTH-1:0]     win_data
);
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned BRM_LO = brm_lsb(WIDTH, WIDTH_BRM);

  logic [WIDTH-1:0]           mem [DEPTH];
  logic [DEPTH-1:0]           vld;
  logic [DEPTH-1:0]           hit;
  logic                       wr_hit;
  logic [LANES-1:0][PW-1:0]   rd_idx;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      hit[i] = brm_hit(32'(mem[i][BRM_LO +: WIDTH_BRM]), 32'(kill));
    wr_hit = brm_hit(32'(wr_data[BRM_LO +: WIDTH_BRM]), 32'(kill));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld <= '0;
    end else begin
      vld <= vld & ~hit;
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        vld[wr_ptr] <= ~wr_hit;
      end
    end
  end

  // Index arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    rd_idx   = '0;
    win_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      rd_idx[k] = rd_ptr + PW'(k);
      if (vld[rd_idx[k]] && !hit[rd_idx[k]]) win_data[k] = mem[rd_idx[k]];
    end
  end

endmodule

// File: rtl/dispatch_packer.sv
// Buffers renamed uops and issues them as registered four-lane groups, flushing
// partial groups after MAX_WAIT idle cycles and zeroing branch-killed uops.
module dispatch_packer
  import dispatch_packer_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned WIDTH_REG = DEF_WIDTH_REG,
  parameter int unsigned WIDTH_TAG = DEF_WIDTH_TAG,
  parameter int unsigned WIDTH_BRM = DEF_WIDTH_BRM,
  parameter int unsigned WIDTH     = uop_width(WIDTH_BRM, WIDTH_TAG, WIDTH_REG),
  parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dispatch_packer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_WAIT_W = WW'(MAX_WAIT);

  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [CW-1:0]                count;
  logic [WW-1:0]                wait_cnt;
  logic                         push, emit;
  logic [2:0]                   n_pop;
  logic [LANES-1:0][WIDTH-1:0]  win_data, lane_data;

  dispatch_ring #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .WIDTH_BRM (WIDTH_BRM)
  ) u_ring (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (push),
    .wr_ptr   (wr_ptr),
    .wr_data  (bus.i_inst),
    .kill     (bus.i_BrKill),
    .rd_ptr   (rd_ptr),
    .win_data (win_data)
  );

  // Ready depends only on the registered count, so a full ring refuses a push even
  // in the cycle that pops a group.
  assign bus.o_ready = (count < CW'(DEPTH));
  assign bus.o_count = count;
  assign push        = bus.i_valid & bus.o_ready;

  always_comb begin
    emit = !bus.i_stall &&
           ((count >= CW'(LANES)) || ((count != '0) && (wait_cnt == MAX_WAIT_W)));
    n_pop = '0;
    if (emit) n_pop = (count >= CW'(LANES)) ? 3'd4 : count[2:0];
    lane_data = '0;
    for (int unsigned k = 0; k < LANES; k++)
      if (3'(k) < n_pop) lane_data[k] = win_data[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wait_cnt    <= '0;
      bus.o_en    <= 1'b0;
      bus.o_inst1 <= '0;
      bus.o_inst2 <= '0;
      bus.o_inst3 <= '0;
      bus.o_inst4 <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(n_pop);
      count  <= count + CW'(push) - CW'(n_pop);
      if (emit || count == '0)
        wait_cnt <= '0;
      else if (!bus.i_stall && count < CW'(LANES) && wait_cnt != MAX_WAIT_W)
        wait_cnt <= wait_cnt + 1'b1;
      bus.o_en    <= emit;
      bus.o_inst1 <= lane_data[0];
      bus.o_inst2 <= lane_data[1];
      bus.o_inst3 <= lane_data[2];
      bus.o_inst4 <= lane_data[3];
    end
  end

endmodule
